conv_2d_ctrl: RTL and testbench

Sequencer for the `conv_2d` 3x3 convolution datapath. It holds a 9-tap kernel shadow register file and loads it into `conv_2d` over three cycles. It then streams a zero-padded frame out of a frame buffer in 3-column strips, asserting `conv_2d`'s data-valid once each window is full. Each convolved pixel is written to the output image buffer at a sequential address. It sits between the host/config bus, the padded-frame memory, `conv_2d`, and the result memory.

---
 rtl/conv_2d_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_conv_2d_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_2d_ctrl.sv
// Sequencer for the conv_2d 3x3 datapath: loads a 9-tap kernel, streams a padded frame in
// 3-column strips and writes each convolved pixel to a sequential result address.
module conv_2d_ctrl #(
  parameter int unsigned IMAGE_HEIGHT = 12,
  parameter int unsigned IMAGE_WIDTH  = 3,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CONV_LAT     = 1,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_knl_wr,
  input  logic [3:0]        i_knl_addr,
  input  logic [DATA_W-1:0] i_knl_data,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_row,
  output logic [ADDR_W-1:0] o_rd_col,
  input  logic [DATA_W-1:0] i_rd_data1,
  input  logic [DATA_W-1:0] i_rd_data2,
  input  logic [DATA_W-1:0] i_rd_data3,
  output logic              o_conv_en,
  output logic              o_conv_load_knl,
  output logic              o_conv_data_valid,
  output logic [DATA_W-1:0] o_conv_data1,
  output logic [DATA_W-1:0] o_conv_data2,
  output logic [DATA_W-1:0] o_conv_data3,
  input  logic [DATA_W-1:0] i_conv_pixel,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_KNL = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMAGE_WIDTH - 3);
  localparam logic [ADDR_W-1:0] WR_LAST  =
      ADDR_W'((IMAGE_HEIGHT - 2) * (IMAGE_WIDTH - 2) - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_WIN  = ADDR_W'(2);

  logic [2:0]          state_q, state_d;
  logic [1:0]          knl_cnt_q, knl_cnt_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   knl_q [9];
  logic                rd_vld_q;   // a read was issued last cycle
  logic                rd_win_q;   // that read completes a 3-row window
  logic                dat_vld_q;
  logic [DATA_W-1:0]   dat1_q, dat2_q, dat3_q;
  logic [CONV_LAT-1:0] vpipe_q, vpipe_d;
  logic                idle, rd_en, wr_en, knl_hit;

  assign idle    = (state_q == IDLE);
  assign rd_en   = (state_q == STREAM);
  assign wr_en   = vpipe_q[CONV_LAT-1];
  assign knl_hit = i_knl_wr && idle && (i_knl_addr >= 4'd1) && (i_knl_addr <= 4'd9);

  always_comb begin
    state_d   = state_q;
    knl_cnt_d = knl_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = LOAD_KNL;
          knl_cnt_d = 2'd0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      LOAD_KNL: begin
        if (knl_cnt_q == 2'd2) begin
          state_d = STREAM;
        end else begin
          knl_cnt_d = knl_cnt_q + 2'd1;
        end
      end
      STREAM: begin
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (col_q == COL_LAST) begin
            state_d = DRAIN;
          end else begin
            col_d = col_q + ADDR_ONE;
          end
        end else begin
          row_d = row_q + ADDR_ONE;
        end
      end
      DRAIN: begin
        if (wr_en && (wr_addr_q == WR_LAST)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    if (idle && i_start) begin
      wr_addr_d = '0;
    end else if (wr_en) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
    end
  end

  always_comb begin
    vpipe_d = (vpipe_q << 1) | CONV_LAT'(dat_vld_q);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      knl_cnt_q <= 2'd0;
      row_q     <= '0;
      col_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      knl_cnt_q <= knl_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Shadow taps only change while idle, so a running frame always sees a stable kernel.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) begin
        knl_q[k] <= '0;
      end
    end else if (knl_hit) begin
      knl_q[i_knl_addr - 4'd1] <= i_knl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_vld_q  <= 1'b0;
      rd_win_q  <= 1'b0;
      dat_vld_q <= 1'b0;
      dat1_q    <= '0;
      dat2_q    <= '0;
      dat3_q    <= '0;
      vpipe_q   <= '0;
    end else begin
      rd_vld_q  <= rd_en;
      rd_win_q  <= rd_en && (row_q >= ROW_WIN);
      dat_vld_q <= rd_win_q;
      vpipe_q   <= vpipe_d;
      if (rd_vld_q) begin
        dat1_q <= i_rd_data1;
        dat2_q <= i_rd_data2;
        dat3_q <= i_rd_data3;
      end else begin
        dat1_q <= '0;
        dat2_q <= '0;
        dat3_q <= '0;
      end
    end
  end

  // Kernel goes out last tap first: (k9,k8,k7), (k6,k5,k4), (k3,k2,k1).
  always_comb begin
    o_conv_data1 = dat1_q;
    o_conv_data2 = dat2_q;
    o_conv_data3 = dat3_q;
    if (state_q == LOAD_KNL) begin
      case (knl_cnt_q)
        2'd0: begin
          o_conv_data1 = knl_q[8];
          o_conv_data2 = knl_q[7];
          o_conv_data3 = knl_q[6];
        end
        2'd1: begin
          o_conv_data1 = knl_q[5];
          o_conv_data2 = knl_q[4];
          o_conv_data3 = knl_q[3];
        end
        default: begin
          o_conv_data1 = knl_q[2];
          o_conv_data2 = knl_q[1];
          o_conv_data3 = knl_q[0];
        end
      endcase
    end
  end

  always_comb begin
    o_busy            = !idle;
    o_done            = (state_q == DONE);
    o_rd_en           = rd_en;
    o_rd_row          = rd_en ? row_q : '0;
    o_rd_col          = rd_en ? col_q : '0;
    o_conv_en         = (state_q == STREAM) || (state_q == DRAIN);
    o_conv_load_knl   = (state_q == LOAD_KNL);
    o_conv_data_valid = dat_vld_q;
    o_wr_en           = wr_en;
    o_wr_addr         = wr_en ? wr_addr_q : '0;
    o_wr_data         = wr_en ? i_conv_pixel : '0;
  end

endmodule

// File: tb/tb_conv_2d_ctrl.sv
// Self-checking bench for conv_2d_ctrl: kernel-write table, randomized frames against a
// frame-level reference model, plus mid-frame reset and minimum-frame sequences.
module tb_conv_2d_ctrl;

  localparam int H     = 5;
  localparam int W     = 5;
  localparam int LAT   = 2;
  localparam int N_RD  = H * (W - 2);
  localparam int N_WR  = (H - 2) * (W - 2);

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         lands;
  } kw_t;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        knl_wr = 1'b0;
  logic [3:0]  knl_addr = 4'd0;
  logic [7:0]  knl_data = 8'd0;
  logic        start = 1'b0;
  logic        busy, done, rd_en, conv_en, load_knl, cv, wr_en;
  logic [15:0] rd_row, rd_col, wr_addr;
  logic [7:0]  rd_data1 = 8'd0, rd_data2 = 8'd0, rd_data3 = 8'd0;
  logic [7:0]  cd1, cd2, cd3, conv_pixel, wr_data;
  logic [7:0]  cq0 = 8'd0, cq1 = 8'd0;

  logic        m_start = 1'b0;
  logic        m_busy, m_done, m_rd_en, m_conv_en, m_load, m_cv, m_wr_en;
  logic [15:0] m_rd_row, m_rd_col, m_wr_addr;
  logic [7:0]  m_cd1, m_cd2, m_cd3, m_wr_data;
  logic [7:0]  m_rd1, m_rd2, m_rd3, m_pix;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  seed = 0;
  int  kmod [10];
  logic busy_prev = 1'b0;

  ev_t load_q [$];
  ev_t rd_q [$];
  ev_t wr_q [$];
  int  vld_q [$];
  int  done_q [$];

  assign m_rd1 = 8'h11;
  assign m_rd2 = 8'h22;
  assign m_rd3 = 8'h33;
  assign m_pix = 8'h5A;
  assign conv_pixel = cq1;

  always #5 clk = ~clk;

  conv_2d_ctrl #(
    .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .DATA_W(8), .CONV_LAT(LAT), .ADDR_W(16)
  ) u_dut (
    .clk(clk), .i_rst(rst), .i_knl_wr(knl_wr), .i_knl_addr(knl_addr),
    .i_knl_data(knl_data), .i_start(start), .o_busy(busy), .o_done(done),
    .o_rd_en(rd_en), .o_rd_row(rd_row), .o_rd_col(rd_col), .i_rd_data1(rd_data1),
    .i_rd_data2(rd_data2), .i_rd_data3(rd_data3), .o_conv_en(conv_en),
    .o_conv_load_knl(load_knl), .o_conv_data_valid(cv), .o_conv_data1(cd1),
    .o_conv_data2(cd2), .o_conv_data3(cd3), .i_conv_pixel(conv_pixel),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
  );

  conv_2d_ctrl #(
    .IMAGE_HEIGHT(3), .IMAGE_WIDTH(3), .DATA_W(8), .CONV_LAT(1), .ADDR_W(16)
  ) u_min (
    .clk(clk), .i_rst(rst), .i_knl_wr(1'b0), .i_knl_addr(4'd0),
    .i_knl_data(8'd0), .i_start(m_start), .o_busy(m_busy), .o_done(m_done),
    .o_rd_en(m_rd_en), .o_rd_row(m_rd_row), .o_rd_col(m_rd_col), .i_rd_data1(m_rd1),
    .i_rd_data2(m_rd2), .i_rd_data3(m_rd3), .o_conv_en(m_conv_en),
    .o_conv_load_knl(m_load), .o_conv_data_valid(m_cv), .o_conv_data1(m_cd1),
    .o_conv_data2(m_cd2), .o_conv_data3(m_cd3), .i_conv_pixel(m_pix),
    .o_wr_en(m_wr_en), .o_wr_addr(m_wr_addr), .o_wr_data(m_wr_data)
  );

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 37 + c * 11 + seed * 3 + 5);
  endfunction

  // Stand-in for conv_2d: any fixed function of the presented window, LAT cycles later.
  function automatic logic [7:0] gfun(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return 8'(int'(a) + 3 * int'(b) + 5 * int'(c));
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data1 <= rd_en ? pix(int'(rd_row), int'(rd_col))     : 8'hEE;
    rd_data2 <= rd_en ? pix(int'(rd_row), int'(rd_col) + 1) : 8'hEE;
    rd_data3 <= rd_en ? pix(int'(rd_row), int'(rd_col) + 2) : 8'hEE;
    cq0 <= gfun(cd1, cd2, cd3);
    cq1 <= cq0;
  end

  always @(negedge clk) begin
    if (load_knl) load_q.push_back('{cyc, int'({cd1, cd2, cd3}), 0});
    if (rd_en) rd_q.push_back('{cyc, int'(rd_row), int'(rd_col)});
    if (cv) vld_q.push_back(cyc);
    if (wr_en) wr_q.push_back('{cyc, int'(wr_addr), int'(wr_data)});
    if (done) done_q.push_back(cyc);
    busy_prev <= busy;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_load(input int c);
    return (kmod[9 - 3 * c] << 16) | (kmod[8 - 3 * c] << 8) | kmod[7 - 3 * c];
  endfunction

  // Cycle of the window-valid for write index k (strip-major order).
  function automatic int exp_vcyc(input int t, input int k);
    int j, i;
    j = k / (H - 2);
    i = k % (H - 2) + 2;
    return t + 4 + j * H + i + 2;
  endfunction

  // Caller must be #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_frame(input string tag, input bit poke, input bit knl_at_start,
                           input int tail);
    int t, b_ld, b_rd, b_v, b_wr, b_dn, after, idle_cyc, exp_done, j, i;
    bit seen;
    b_ld = load_q.size(); b_rd = rd_q.size(); b_v = vld_q.size();
    b_wr = wr_q.size(); b_dn = done_q.size();
    seed = int'($urandom_range(0, 255));
    start = 1'b1;
    t = cyc;
    if (knl_at_start) begin
      knl_wr = 1'b1; knl_addr = 4'd9; knl_data = 8'($urandom);
      kmod[9] = int'(knl_data);
    end
    seen = 0; after = 0; idle_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = 1'b0; knl_wr = 1'b0;
      if (poke && rd_en && rd_row == 16'd1 && rd_col == 16'd0) begin
        start = 1'b1; knl_wr = 1'b1; knl_addr = 4'd5; knl_data = 8'(~kmod[5]);
      end
      if (poke && done) start = 1'b1;
      if (seen && !busy) begin
        if (idle_cyc < 0) idle_cyc = cyc;
        after++;
      end
      if (done) seen = 1;
      if (after > tail) break;
    end
    exp_done = t + 4 + (N_RD - 1) + 2 + LAT + 1;

    check({tag, "_load_n"}, load_q.size() - b_ld, 3);
    for (int k = 0; k < 3 && b_ld + k < load_q.size(); k++) begin
      check({tag, "_load_cyc"}, load_q[b_ld + k].cyc, t + 1 + k);
      check({tag, "_load_dat"}, load_q[b_ld + k].a, exp_load(k));
    end
    check({tag, "_rd_n"}, rd_q.size() - b_rd, N_RD);
    for (int k = 0; k < N_RD && b_rd + k < rd_q.size(); k++) begin
      check({tag, "_rd_cyc"}, rd_q[b_rd + k].cyc, t + 4 + k);
      check({tag, "_rd_pos"}, rd_q[b_rd + k].a * 256 + rd_q[b_rd + k].b,
            (k % H) * 256 + k / H);
    end
    check({tag, "_vld_n"}, vld_q.size() - b_v, N_WR);
    for (int k = 0; k < N_WR && b_v + k < vld_q.size(); k++)
      check({tag, "_vld_cyc"}, vld_q[b_v + k], exp_vcyc(t, k));
    check({tag, "_wr_n"}, wr_q.size() - b_wr, N_WR);
    for (int k = 0; k < N_WR && b_wr + k < wr_q.size(); k++) begin
      j = k / (H - 2);
      i = k % (H - 2) + 2;
      check({tag, "_wr_cyc"}, wr_q[b_wr + k].cyc, exp_vcyc(t, k) + LAT);
      check({tag, "_wr_addr"}, wr_q[b_wr + k].a, k);
      check({tag, "_wr_data"}, wr_q[b_wr + k].b,
            int'(gfun(pix(i, j), pix(i, j + 1), pix(i, j + 2))));
    end
    check({tag, "_done_n"}, done_q.size() - b_dn, 1);
    if (done_q.size() > b_dn) check({tag, "_done_cyc"}, done_q[b_dn], exp_done);
    check({tag, "_idle_cyc"}, idle_cyc, exp_done + 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kw_t kw_tab [12];
    int  t, rcyc, b_wr, b_dn, exp_wr;
    int  m_first, m_rd_n, m_wr_n, m_wa, m_wd, m_wc, m_dc;

    for (int k = 0; k < 10; k++) kmod[k] = 0;
    for (int k = 0; k < 9; k++) kw_tab[k] = '{4'(k + 1), 8'($urandom), 1'b1};
    kw_tab[9]  = '{4'd0,  8'($urandom), 1'b0};
    kw_tab[10] = '{4'd12, 8'($urandom), 1'b0};
    kw_tab[11] = '{4'd15, 8'($urandom), 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("por_outs", {31'd0, |{busy, done, rd_en, rd_row, rd_col, conv_en, load_knl, cv,
                               cd1, cd2, cd3, wr_en, wr_addr, wr_data}}, 0);
    check("por_min_outs", {31'd0, |{m_busy, m_done, m_rd_en, m_load, m_cv, m_wr_en}}, 0);

    for (int k = 0; k < 12; k++) begin
      knl_wr = 1'b1; knl_addr = kw_tab[k].addr; knl_data = kw_tab[k].data;
      @(posedge clk); #1;
      knl_wr = 1'b0;
      if (kw_tab[k].lands) kmod[kw_tab[k].addr] = int'(kw_tab[k].data);
    end

    run_frame("f1", 1'b0, 1'b0, 12);
    run_frame("f2", 1'b1, 1'b0, 0);
    run_frame("f3", 1'b0, 1'b1, 12);

    // Reset in the middle of the second strip.
    b_wr = wr_q.size(); b_dn = done_q.size();
    seed = int'($urandom_range(0, 255));
    start = 1'b1;
    t = cyc;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rd_en && rd_row == 16'd2 && rd_col == 16'd1) break;
    end
    rst = 1'b1;
    rcyc = cyc;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_outs", {31'd0, |{busy, done, rd_en, rd_row, rd_col, conv_en, load_knl, cv,
                               cd1, cd2, cd3, wr_en, wr_addr, wr_data}}, 0);
    repeat (20) @(posedge clk);
    #1;
    exp_wr = 0;
    for (int k = 0; k < N_WR; k++) if (exp_vcyc(t, k) + LAT <= rcyc) exp_wr++;
    check("rst_wr_n", wr_q.size() - b_wr, exp_wr);
    check("rst_done_n", done_q.size() - b_dn, 0);
    for (int k = 0; k < 10; k++) kmod[k] = 0;
    run_frame("f4", 1'b0, 1'b0, 12);

    // Minimum 3x3 frame on the second instance.
    m_first = -1; m_rd_n = 0; m_wr_n = 0; m_wa = -1; m_wd = -1; m_wc = -1; m_dc = -1;
    m_start = 1'b1;
    t = cyc;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      m_start = 1'b0;
      if (m_rd_en) begin
        if (m_first < 0) m_first = cyc;
        m_rd_n++;
      end
      if (m_wr_en) begin
        m_wr_n++; m_wa = int'(m_wr_addr); m_wd = int'(m_wr_data); m_wc = cyc;
      end
      if (m_done) m_dc = cyc;
    end
    check("min_rd_first", m_first, t + 4);
    check("min_rd_n", m_rd_n, 3);
    check("min_wr_n", m_wr_n, 1);
    check("min_wr_addr", m_wa, 0);
    check("min_wr_data", m_wd, 'h5A);
    check("min_wr_cyc", m_wc, t + 9);
    check("min_done_cyc", m_dc, t + 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
